// File: rtl/otter_intr_ctrl_if.sv
// Core/CSR side of the OTTER interrupt controller: register bus plus the request handshake.
interface otter_intr_ctrl_if;
  logic        INTC_mie;
  logic        INTC_int_taken;
  logic        INTC_mret_exec;
  logic        INTC_we;
  logic [1:0]  INTC_addr;
  logic [31:0] INTC_wd;
  logic [31:0] INTC_rd;
  logic        INTC_intr;
  logic [31:0] INTC_cause;
  logic        INTC_busy;

  modport master (
    output INTC_mie, INTC_int_taken, INTC_mret_exec, INTC_we, INTC_addr, INTC_wd,
    input  INTC_rd, INTC_intr, INTC_cause, INTC_busy
  );

  modport slave (
    input  INTC_mie, INTC_int_taken, INTC_mret_exec, INTC_we, INTC_addr, INTC_wd,
    output INTC_rd, INTC_intr, INTC_cause, INTC_busy
  );
endinterface

// File: rtl/otter_intr_ctrl.sv
// Edge-triggered, fixed-priority interrupt controller for the OTTER CSR unit.
//   state      | meaning
//   ST_IDLE    | no request; winner picked from pending & enable when mie is set
//   ST_REQ     | INTC_intr high for sel_id, waiting for int_taken or retraction
//   ST_SERVICE | handler running (INTC_busy), waiting for mret_exec
module otter_intr_ctrl #(
  parameter int N_SRC      = 8,
  parameter int CAUSE_BASE = 16
) (
  input  logic             INTC_clk,
  input  logic             INTC_reset_n,
  input  logic [N_SRC-1:0] INTC_src,
  otter_intr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [4:0]       sel_id_q, sel_id_d;
  logic [4:0]       win_id;
  logic [N_SRC-1:0] rise, active, sel_oh, clr_w1c, clr_take;
  logic             unused_wd;

  assign unused_wd = ^bus.INTC_wd;

  assign rise   = sync2_q & ~prev_q;
  assign active = pending_q & enable_q;

  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_id = 5'(i);
    end
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      sel_oh[i] = (sel_id_q == 5'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_id_d = sel_id_q;
    clr_take = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.INTC_mie && (|active)) begin
          sel_id_d = win_id;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.INTC_int_taken) begin
          clr_take = sel_oh;
          state_d  = ST_SERVICE;
        end else if (!bus.INTC_mie || !(|(enable_q & sel_oh)) || !(|(pending_q & sel_oh))) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus.INTC_mret_exec) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A rising edge in the same cycle as a W1C or a take keeps the bit set.
  always_comb begin
    clr_w1c   = (bus.INTC_we && bus.INTC_addr == 2'd1) ? bus.INTC_wd[N_SRC-1:0] : '0;
    pending_d = (pending_q & ~(clr_w1c | clr_take)) | rise;
    enable_d  = (bus.INTC_we && bus.INTC_addr == 2'd0) ? bus.INTC_wd[N_SRC-1:0] : enable_q;
  end

  always_ff @(posedge INTC_clk or negedge INTC_reset_n) begin
    if (!INTC_reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      sel_id_q  <= '0;
      state_q   <= ST_IDLE;
    end else begin
      sync1_q   <= INTC_src;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      sel_id_q  <= sel_id_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    bus.INTC_rd = '0;
    case (bus.INTC_addr)
      2'd0: bus.INTC_rd[N_SRC-1:0] = enable_q;
      2'd1: bus.INTC_rd[N_SRC-1:0] = pending_q;
      2'd2: if (state_q != ST_IDLE) bus.INTC_rd[4:0] = sel_id_q;
      default: bus.INTC_rd = '0;
    endcase
  end

  assign bus.INTC_intr  = (state_q == ST_REQ);
  assign bus.INTC_busy  = (state_q == ST_SERVICE);
  assign bus.INTC_cause = 32'h8000_0000 | (32'(CAUSE_BASE) + {27'b0, sel_id_q});

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Bench for otter_intr_ctrl: register vector table, directed corner sequences, random run vs model.
module tb_otter_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src;

  otter_intr_ctrl_if bus ();

  otter_intr_ctrl #(.N_SRC(8), .CAUSE_BASE(16)) dut (
    .INTC_clk     (clk),
    .INTC_reset_n (rst_n),
    .INTC_src     (src),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference: src samples from the last three edges, pending/enable bit sets,
  // and whether a request or a service is outstanding.
  bit [7:0] m_en, m_pend, m_h1, m_h2, m_h3;
  bit       m_req, m_srv;
  int       m_sel;
  bit [7:0] m_rise, m_clr, m_act;

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_pend = 0; m_h1 = 0; m_h2 = 0; m_h3 = 0;
      m_req = 0; m_srv = 0; m_sel = 0;
    end else begin
      // src first seen high two edges ago and low three edges ago -> new pending event
      m_rise = m_h2 & ~m_h3;
      m_clr  = (bus.INTC_we && bus.INTC_addr == 2'd1) ? bus.INTC_wd[7:0] : 8'h00;
      m_act  = m_pend & m_en;
      if (m_req) begin
        if (bus.INTC_int_taken) begin
          m_clr[m_sel] = 1'b1;
          m_req = 0; m_srv = 1;
        end else if (!bus.INTC_mie || !m_en[m_sel] || !m_pend[m_sel]) begin
          m_req = 0;
        end
      end else if (m_srv) begin
        if (bus.INTC_mret_exec) m_srv = 0;
      end else if (bus.INTC_mie && m_act != 0) begin
        m_sel = lowest(m_act);
        m_req = 1;
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
      if (bus.INTC_we && bus.INTC_addr == 2'd0) m_en = bus.INTC_wd[7:0];
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = src;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_at(input logic [1:0] a, output logic [31:0] d);
    bus.INTC_addr = a;
    #1;
    d = bus.INTC_rd;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.INTC_we = 1'b1; bus.INTC_addr = a; bus.INTC_wd = d;
    step();
    bus.INTC_we = 1'b0;
  endtask

  task automatic pulse_taken();
    bus.INTC_int_taken = 1'b1; step(); bus.INTC_int_taken = 1'b0;
  endtask

  task automatic pulse_mret();
    bus.INTC_mret_exec = 1'b1; step(); bus.INTC_mret_exec = 1'b0;
  endtask

  task automatic wait_intr(input string name, input int bound);
    int n = 0;
    while (bus.INTC_intr !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk(name, {31'b0, bus.INTC_intr}, 32'd1);
  endtask

  task automatic check_model(input string name);
    logic [31:0] d;
    chk({name, ".intr"},  {31'b0, bus.INTC_intr}, {31'b0, m_req});
    chk({name, ".busy"},  {31'b0, bus.INTC_busy}, {31'b0, m_srv});
    chk({name, ".cause"}, bus.INTC_cause, 32'h8000_0000 | 32'(16 + m_sel));
    rd_at(2'd0, d); chk({name, ".enable"},  d, {24'b0, m_en});
    rd_at(2'd1, d); chk({name, ".pending"}, d, {24'b0, m_pend});
    rd_at(2'd2, d); chk({name, ".claim"},   d, (m_req || m_srv) ? 32'(m_sel) : 32'd0);
    rd_at(2'd3, d); chk({name, ".rsvd"},    d, 32'd0);
  endtask

  typedef struct {
    bit          we;
    bit [1:0]    addr;
    bit [31:0]   wd;
    bit [31:0]   exp_rd;
  } reg_vec_t;

  reg_vec_t    tbl[8];
  logic [31:0] d;
  int          events;

  initial begin
    rst_n = 1'b0; src = '0;
    bus.INTC_mie = 0; bus.INTC_int_taken = 0; bus.INTC_mret_exec = 0;
    bus.INTC_we = 0; bus.INTC_addr = 0; bus.INTC_wd = 0;
    step(); step();
    rst_n = 1'b1;

    chk("rst.intr",  {31'b0, bus.INTC_intr}, 32'd0);
    chk("rst.busy",  {31'b0, bus.INTC_busy}, 32'd0);
    chk("rst.cause", bus.INTC_cause, 32'h8000_0010);
    check_model("rst");

    tbl[0] = '{1'b1, 2'd0, 32'h0000_00FF, 32'h0000_00FF};
    tbl[1] = '{1'b1, 2'd0, 32'hABCD_1234, 32'h0000_0034};
    tbl[2] = '{1'b0, 2'd1, 32'h0,         32'h0};
    tbl[3] = '{1'b0, 2'd2, 32'h0,         32'h0};
    tbl[4] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    tbl[5] = '{1'b0, 2'd0, 32'h0,         32'h0000_0034};
    tbl[6] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
    tbl[7] = '{1'b1, 2'd0, 32'h0,         32'h0};
    for (int i = 0; i < 8; i++) begin
      bus.INTC_we = tbl[i].we; bus.INTC_addr = tbl[i].addr; bus.INTC_wd = tbl[i].wd;
      step();
      bus.INTC_we = 1'b0;
      #1;
      chk($sformatf("tbl[%0d].rd", i), bus.INTC_rd, tbl[i].exp_rd);
    end

    // Basic request/take/return with edge-to-request timing
    wr(2'd0, 32'h08);
    bus.INTC_mie = 1'b1;
    src[3] = 1'b1;
    step();
    step();
    rd_at(2'd1, d); chk("basic.pend_k1", d, 32'h0);
    step();
    rd_at(2'd1, d); chk("basic.pend_k2", d, 32'h08);
    chk("basic.intr_k2", {31'b0, bus.INTC_intr}, 32'd0);
    step();
    chk("basic.intr_k3", {31'b0, bus.INTC_intr}, 32'd1);
    chk("basic.cause", bus.INTC_cause, 32'h8000_0013);
    pulse_taken();
    chk("basic.busy", {31'b0, bus.INTC_busy}, 32'd1);
    rd_at(2'd1, d); chk("basic.pend_taken", d, 32'h0);
    src[3] = 1'b0;
    pulse_mret();
    chk("basic.idle_busy", {31'b0, bus.INTC_busy}, 32'd0);
    chk("basic.idle_intr", {31'b0, bus.INTC_intr}, 32'd0);
    check_model("basic");

    // Fixed priority between simultaneous edges
    wr(2'd0, 32'hFF);
    src = 8'h24;
    wait_intr("prio.req1", 10);
    rd_at(2'd2, d); chk("prio.claim1", d, 32'd2);
    chk("prio.cause1", bus.INTC_cause, 32'h8000_0012);
    pulse_taken();
    src = 8'h00;
    pulse_mret();
    wait_intr("prio.req2", 10);
    rd_at(2'd2, d); chk("prio.claim2", d, 32'd5);
    chk("prio.cause2", bus.INTC_cause, 32'h8000_0015);
    pulse_taken();
    pulse_mret();
    check_model("prio");

    // Retraction by mie and by ENABLE; the enable write only counts from the next edge
    src[1] = 1'b1;
    wait_intr("retr.req", 10);
    rd_at(2'd2, d); chk("retr.claim", d, 32'd1);
    bus.INTC_mie = 1'b0;
    step();
    chk("retr.mie_off", {31'b0, bus.INTC_intr}, 32'd0);
    rd_at(2'd1, d); chk("retr.pend_kept", d & 32'h2, 32'h2);
    bus.INTC_mie = 1'b1;
    step();
    chk("retr.mie_on", {31'b0, bus.INTC_intr}, 32'd1);
    wr(2'd0, 32'hFD);
    chk("retr.en_write_edge", {31'b0, bus.INTC_intr}, 32'd1);
    step();
    chk("retr.en_off", {31'b0, bus.INTC_intr}, 32'd0);
    wr(2'd0, 32'hFF);
    wait_intr("retr.req_again", 10);
    src[1] = 1'b0;
    pulse_taken();
    pulse_mret();
    check_model("retr");

    // Set beats W1C in the same cycle; a held level yields one event only
    bus.INTC_mie = 1'b0;
    src[4] = 1'b1;
    step();
    step();
    bus.INTC_we = 1'b1; bus.INTC_addr = 2'd1; bus.INTC_wd = 32'h10;
    step();
    bus.INTC_we = 1'b0;
    rd_at(2'd1, d); chk("coll.set_wins", d, 32'h10);
    wr(2'd1, 32'h10);
    rd_at(2'd1, d); chk("coll.cleared", d, 32'h0);
    src[4] = 1'b0;
    repeat (4) step();
    src[4] = 1'b1;
    events = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      rd_at(2'd1, d);
      if (d[4]) begin
        events++;
        wr(2'd1, 32'h10);
      end
    end
    chk("coll.one_event", 32'(events), 32'd1);
    src[4] = 1'b0;
    repeat (4) step();
    check_model("coll");

    // Handshake pulses outside their state are ignored
    pulse_taken();
    chk("ign.taken_idle_intr", {31'b0, bus.INTC_intr}, 32'd0);
    chk("ign.taken_idle_busy", {31'b0, bus.INTC_busy}, 32'd0);
    bus.INTC_mie = 1'b1;
    src[0] = 1'b1;
    wait_intr("ign.req", 10);
    pulse_mret();
    chk("ign.mret_req_intr", {31'b0, bus.INTC_intr}, 32'd1);
    chk("ign.mret_req_busy", {31'b0, bus.INTC_busy}, 32'd0);
    src[0] = 1'b0;
    pulse_taken();
    pulse_mret();
    check_model("ign");

    // Asynchronous reset in the middle of a request
    wr(2'd0, 32'hFF);
    src[3] = 1'b1;
    step();
    src[3] = 1'b0;
    wait_intr("rstmid.req", 10);
    rst_n = 1'b0;
    #1;
    chk("rstmid.intr", {31'b0, bus.INTC_intr}, 32'd0);
    chk("rstmid.busy", {31'b0, bus.INTC_busy}, 32'd0);
    rd_at(2'd1, d); chk("rstmid.pend", d, 32'h0);
    check_model("rstmid");
    step();
    rst_n = 1'b1;
    step();

    // Random traffic against the model
    wr(2'd0, 32'hFF);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) src[$urandom_range(0, 7)] = ~src[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) src ^= 8'(1 << $urandom_range(0, 7));
      bus.INTC_mie       = ($urandom_range(0, 9) != 0);
      bus.INTC_int_taken = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      bus.INTC_mret_exec = m_srv ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) begin
        bus.INTC_we   = 1'b1;
        bus.INTC_addr = 2'($urandom_range(0, 3));
        bus.INTC_wd   = $urandom;
      end
      step();
      bus.INTC_we = 1'b0; bus.INTC_int_taken = 1'b0; bus.INTC_mret_exec = 1'b0;
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
